// File: rtl/fade_pwm_multi_if.sv
// Control and observation bundle for the multi-channel fade/PWM engine.
// The controller side drives enable/mode and observes the per-channel outputs.
`timescale 1ns/1ps
interface fade_pwm_multi_if #(
  parameter int NUM_CH = 3,
  parameter int VW     = 11
);
  logic                   enable;
  logic                   mode;
  logic [NUM_CH-1:0]      pwm_out;
  logic [NUM_CH*VW-1:0]   pwm_value;
  logic                   period_start;

  modport master (
    output enable,
    output mode,
    input  pwm_out,
    input  pwm_value,
    input  period_start
  );

  modport slave (
    input  enable,
    input  mode,
    output pwm_out,
    output pwm_value,
    output period_start
  );
endinterface

// File: rtl/fade_pwm_multi.sv
// Multi-channel LED fade engine: shared PWM timebase and step timer, per-channel
// triangle/sawtooth brightness ramp with phase offset, duty latched at period end.
`timescale 1ns/1ps
module fade_pwm_multi #(
  parameter int PWM_INTERVAL  = 1200,
  parameter int STEP_INTERVAL = 12000,
  parameter int NUM_STEPS     = 200,
  parameter int NUM_CH        = 3
) (
  input  logic            clk,
  input  logic            rst,
  fade_pwm_multi_if.slave bus
);
  localparam int VW      = $clog2(PWM_INTERVAL + 1);
  localparam int PWM_INC = PWM_INTERVAL / NUM_STEPS;
  localparam int CW      = $clog2(PWM_INTERVAL);
  localparam int SW      = $clog2(STEP_INTERVAL + 1);
  localparam int TW      = $clog2(2 * NUM_STEPS);
  localparam int TXW     = TW + 1;
  localparam int LW      = $clog2(NUM_STEPS + 1);

  logic [CW-1:0] cnt_reg;
  logic [SW-1:0] stp_reg;
  logic          period_start_reg;
  logic          cnt_last;
  logic          tick;

  assign cnt_last = (cnt_reg == CW'(PWM_INTERVAL - 1));
  assign tick     = bus.enable && (stp_reg == SW'(STEP_INTERVAL - 1));

  // The PWM timebase free-runs regardless of enable; only the step timer pauses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg          <= '0;
      stp_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= cnt_last ? '0 : cnt_reg + 1'b1;
      period_start_reg <= cnt_last;
      if (bus.enable) begin
        stp_reg <= tick ? '0 : stp_reg + 1'b1;
      end
    end
  end

  assign bus.period_start = period_start_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [TW-1:0] T_RST = TW'((gi * 2 * NUM_STEPS) / NUM_CH);

    logic [TW-1:0] t_reg;
    logic [LW-1:0] lvl;
    logic [VW-1:0] duty_reg;
    logic [VW-1:0] duty_next;
    logic          pwm_reg;

    // Second half of the phase either descends (triangle) or restarts (sawtooth).
    always_comb begin
      lvl = '0;
      if (t_reg < TW'(NUM_STEPS)) begin
        lvl = LW'(t_reg);
      end else if (bus.mode) begin
        lvl = LW'(t_reg - TW'(NUM_STEPS));
      end else begin
        lvl = LW'(TXW'(2 * NUM_STEPS) - {1'b0, t_reg});
      end
    end

    assign duty_next = VW'(lvl) * VW'(PWM_INC);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        t_reg    <= T_RST;
        duty_reg <= '0;
        pwm_reg  <= 1'b0;
      end else begin
        if (tick) begin
          t_reg <= (t_reg == TW'(2 * NUM_STEPS - 1)) ? '0 : t_reg + 1'b1;
        end
        // Latching only at period end keeps every PWM period glitch-free.
        if (cnt_last) begin
          duty_reg <= duty_next;
        end
        pwm_reg <= bus.enable && (VW'(cnt_reg) < duty_reg);
      end
    end

    assign bus.pwm_out[gi]              = pwm_reg;
    assign bus.pwm_value[gi*VW +: VW]   = duty_reg;
  end

endmodule

// File: doc/fade_pwm_multi.md
# fade_pwm_multi

Multi-channel LED fade engine: one shared PWM timebase driving NUM_CH PWM outputs. Each channel brightness ramps automatically in triangle (breathing) or sawtooth mode, with a fixed per-channel phase offset so that channels fade out of step. Duty updates are glitch-free because they take effect only at PWM period boundaries. The block sits directly between the top level and the RGB/LED pins, and replaces the separate single-channel fade and pwm pair.

## Interface
- PWM_INTERVAL, 1200: PWM period in clk cycles (≥2).
- STEP_INTERVAL, 12000: clk cycles between brightness steps (≥1).
- NUM_STEPS, 200: steps per ramp, from 0 to full. PWM_INTERVAL must be divisible by NUM_STEPS. PWM_INC = PWM_INTERVAL/NUM_STEPS.
- NUM_CH, 3: channel count (≥1).
- VW (local), $clog2(PWM_INTERVAL+1): duty width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run; 0 = freeze ramps and force outputs low.
- mode  in  1  0 = triangle, 1 = sawtooth.
- pwm_out  out  NUM_CH  per-channel PWM, registered.
- pwm_value  out  NUM_CH*VW  latched duty per channel, packed; channel i occupies [i*VW +: VW].
- period_start  out  1  one-cycle pulse on the first cycle of each PWM period.

## Operation
- cnt: shared counter, 0..PWM_INTERVAL-1, wraps. It runs even when enable=0.
- stp: shared counter, 0..STEP_INTERVAL-1. It advances only when enable=1. tick = enable && stp==STEP_INTERVAL-1.
- t_i: per-channel phase, range 0..2*NUM_STEPS-1. On tick it does t_i <= (t_i+1) mod 2*NUM_STEPS. Reset value is (i*2*NUM_STEPS)/NUM_CH, using integer division.
- Level, with N = NUM_STEPS:
  - Triangle: lvl_i = t_i<N ? t_i : 2N-t_i. The range is 0..N, and peak N is reached at t_i=N.
  - Sawtooth: lvl_i = t_i<N ? t_i : t_i-N. The range is 0..N-1, and it wraps to 0.
- Duty latch: in the cycle where cnt==PWM_INTERVAL-1, duty_i <= lvl_i*PWM_INC. Here lvl_i is the value held in that cycle, before any tick in the same cycle. pwm_value outputs duty_i.
- Output: pwm_out[i] <= enable && (cnt < duty_i).
  - duty 0 gives a constant low output.
  - duty PWM_INTERVAL gives a constant high output.
- Mode changes are combinational into lvl. They become visible only at the next duty latch and never mid-period. t_i is not altered by a mode change.
- enable=0:
  - stp and t_i hold.
  - Duty latching continues.
  - pwm_out goes low on the next cycle.
  - When enable is reasserted, ramps resume from the held t_i with no reset.

## Timing
- Reset values:
  - cnt=0, stp=0.
  - t_i = the offsets defined above.
  - duty_i = 0, pwm_value = 0.
  - pwm_out = 0.
  - period_start = 0.
- Reset may assert at any cycle. It takes effect asynchronously with no partial state, and the first edge after release counts as cycle 0.
- period_start is registered. It is 1 in cycle k+1 when cnt(k)==PWM_INTERVAL-1, which is the same cycle that the new duty_i becomes visible. The first pulse is at cycle PWM_INTERVAL.
- pwm_out has 1-cycle latency from cnt/duty. A period's high run for duty d spans cycles PWM_INTERVAL*m+1 .. PWM_INTERVAL*m+d.
- A tick and a duty latch in the same cycle: the latch uses the old level, and the new level appears one PWM period later.
- Duty changes by at most PWM_INC per period per channel. The exception is the sawtooth wrap, where it drops (N-1)*PWM_INC → 0.
- All arithmetic is unsigned. lvl*PWM_INC ≤ PWM_INTERVAL always fits VW.

## Test plan
Common parameters: PWM_INTERVAL=8, STEP_INTERVAL=16, NUM_STEPS=4, NUM_CH=2, so PWM_INC=2. Offsets are t0=0 and t1=4.

- **Reset and first latch.** Hold rst, release, enable=1, mode=0.
  - pwm_out=00, pwm_value=0 until cycle 8.
  - period_start first pulses at cycle 8.
  - ch1 duty=8, so pwm_out[1]=1 for whole periods. ch0 duty=0.
- **Triangle sweep.** Run 2*4*16 cycles. ch0 pwm_value steps 0,2,4,6,8,6,4,2,0, changing only on period_start cycles. ch1 is 8,6,…, in antiphase.
- **Sawtooth.** mode=1 from reset.
  - ch0: 0,2,4,6,0,…
  - ch1 (t1=4): starts at 0.
  - Neither channel ever reaches duty 8.
- **Duty shape.** Latch ch0 duty=6. pwm_out[0] is high for exactly 6 of 8 cycles, starting 1 cycle after cnt=0.
- **Enable pause.**
  - Drop enable mid-ramp: pwm_out=00 on the next cycle, and t_i holds for 100 cycles.
  - Reassert enable: the ramp continues from the same value.
- **Mid-period mode switch and async reset.**
  - Toggle mode at cnt=3: the duty is unchanged until the next period_start.
  - Pulse rst between clk edges: all outputs are 0 immediately and t_i returns to 0/4.
